// File: rtl/gate_arbiter_if.sv
// gate_arbiter_if: request/response bundle between two requesters, the arbiter and one consumer.
//   master: drives req*_valid/a/b/op and rsp_ready; sees req*_ready and rsp_valid/id/y.
//   slave : the arbiter side of the same signals.
interface gate_arbiter_if #(parameter int WIDTH = 8) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/gate_arbiter.sv
// gate_arbiter: two-requester round-robin arbiter feeding a one-deep NAND/NOR result register.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : gate_arbiter_if.slave (requests in, readies out, result out)
//   gnt_cnt0/1: saturating 8-bit accepted-transfer counters, present only with GATE_ARBITER_STATS_EN
module gate_arbiter #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    gate_arbiter_if.slave bus
`ifdef GATE_ARBITER_STATS_EN
    ,
    output logic [7:0]    gnt_cnt0,
    output logic [7:0]    gnt_cnt1
`endif
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             gnt, open, rdy0, rdy1, xfer, op;
    logic [WIDTH-1:0] a, b;

    always_comb begin
        // With a lone valid requester it wins; with two, the one not served last wins.
        gnt = (bus.req0_valid && bus.req1_valid) ? !last_grant_q : bus.req1_valid;
        open = (state_q == EMPTY) || bus.rsp_ready;
        rdy0 = open && bus.req0_valid && !gnt;
        rdy1 = open && bus.req1_valid && gnt;
        xfer = rdy0 || rdy1;
        a = gnt ? bus.req1_a : bus.req0_a;
        b = gnt ? bus.req1_b : bus.req0_b;
        op = gnt ? bus.req1_op : bus.req0_op;
        state_d = xfer ? FULL : (bus.rsp_ready ? EMPTY : state_q);
        last_grant_d = xfer ? gnt : last_grant_q;
        rsp_id_d = xfer ? gnt : rsp_id_q;
        rsp_y_d = xfer ? (op ? ~(a | b) : ~(a & b)) : rsp_y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_id_q <= 1'b0;
            rsp_y_q <= '0;
        end else begin
            state_q <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q <= rsp_id_d;
            rsp_y_q <= rsp_y_d;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id = rsp_id_q;
    assign bus.rsp_y = rsp_y_q;

`ifdef GATE_ARBITER_STATS_EN
    logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = (rdy0 && cnt0_q != 8'hFF) ? cnt0_q + 8'd1 : cnt0_q;
        cnt1_d = (rdy1 && cnt1_q != 8'hFF) ? cnt1_q + 8'd1 : cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: scoreboard bench for gate_arbiter with directed and random stimulus.
module tb_gate_arbiter;
    localparam int W = 8;

    typedef struct packed {
        logic         id;
        logic [W-1:0] y;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_arbiter_if #(.WIDTH(W)) bus ();
`ifdef GATE_ARBITER_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    gate_arbiter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef GATE_ARBITER_STATS_EN
        ,
        .gnt_cnt0(gnt_cnt0),
        .gnt_cnt1(gnt_cnt1)
`endif
    );

    rsp_t q[$];
    int   checks = 0;
    int   fails = 0;
    bit   m_full = 1'b0;
    bit   m_last = 1'b1;
    int   cnt0 = 0;
    int   cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gate(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        return op ? ~(a | b) : ~(a & b);
    endfunction

    // Drives one cycle at edge+2, predicts readies at edge+7, returns at next edge+2.
    task automatic step(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic op0,
                        input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                        input logic rr, output logic acc0, output logic acc1);
        logic open, g;
        rsp_t e;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp_ready = rr;
        #5;
        open = !m_full || rr;
        g = (v0 && v1) ? !m_last : v1;
        acc0 = open && v0 && !g;
        acc1 = open && v1 && g;
        check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, acc0});
        check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, acc1});
        if (acc0 || acc1) begin
            e.id = acc1;
            e.y = acc1 ? gate(a1, b1, op1) : gate(a0, b0, op0);
            q.push_back(e);
            m_last = acc1;
            m_full = 1'b1;
            if (acc1) cnt1++; else cnt0++;
        end else if (rr) m_full = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rr);
        logic x0, x1;
        step(0, 0, 0, 0, 0, 0, 0, 0, rr, x0, x1);
    endtask

    task automatic mid_reset();
        #1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_y", {24'd0, bus.rsp_y}, 32'd0);
        check("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        q.delete();
        m_full = 1'b0;
        m_last = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rsp_t h;
        forever begin
            @(posedge clk);
            #6;
            if (rst_n) begin
                check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, q.size() != 0});
                check("ready_onehot", {31'd0, bus.req0_ready && bus.req1_ready}, 32'd0);
                if (bus.rsp_valid && q.size() != 0) begin
                    h = q[0];
                    check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, h.id});
                    check("rsp_y", {24'd0, bus.rsp_y}, {24'd0, h.y});
                    if (bus.rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic x0, x1;
        logic p0, p1, o0, o1, rr;
        logic [W-1:0] a0, b0, a1, b1;
        logic [31:0] r;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp_ready = 0;
        #1;
        check("init_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("init_rsp_y", {24'd0, bus.rsp_y}, 32'd0);
        check("init_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // single NAND on req0, then single NOR on req1
        step(1, 8'hF0, 8'h3C, 0, 0, 0, 0, 0, 1, x0, x1);
        check("nand_accept", {31'd0, x0}, 32'd1);
        step(0, 0, 0, 0, 1, 8'h0F, 8'h30, 1, 1, x0, x1);
        check("nor_accept", {31'd0, x1}, 32'd1);
        idle(1);
        // contention after reset
        mid_reset();
        for (int i = 0; i < 4; i++) step(1, 8'(i), 8'hA5, 0, 1, 8'(i + 7), 8'h5A, 1, 1, x0, x1);
        // stall three cycles with req1 pending, then release
        step(1, 8'h12, 8'h34, 0, 0, 0, 0, 0, 1, x0, x1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h55, 8'h0F, 1, 0, x0, x1);
        step(0, 0, 0, 0, 1, 8'h55, 8'h0F, 1, 1, x0, x1);
        check("stall_release", {31'd0, x1}, 32'd1);
        // reset in the middle of a stall, then contention must start with req0
        step(0, 0, 0, 0, 1, 8'h77, 8'h88, 0, 0, x0, x1);
        mid_reset();
        step(1, 8'hFF, 8'h0F, 0, 1, 8'h00, 8'h01, 1, 1, x0, x1);
        check("post_reset_first", {31'd0, x0}, 32'd1);
        idle(1);
        // random phase with held pending requests
        p0 = 0; p1 = 0; o0 = 0; o1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        for (int i = 0; i < 500; i++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin
                r = $urandom; a0 = r[7:0]; b0 = r[15:8]; o0 = r[16]; p0 = 1;
            end
            if (!p1 && $urandom_range(1, 0) == 1) begin
                r = $urandom; a1 = r[7:0]; b1 = r[15:8]; o1 = r[16]; p1 = 1;
            end
            rr = ($urandom_range(3, 0) != 0);
            step(p0, a0, b0, o0, p1, a1, b1, o1, rr, x0, x1);
            if (x0) p0 = 0;
            if (x1) p1 = 0;
        end
        for (int i = 0; i < 3; i++) idle(1);
        // many req0 transfers for the saturating counters
        for (int i = 0; i < 300; i++) step(1, 8'(i), 8'(i * 3), i[0], 0, 0, 0, 0, 1, x0, x1);
        for (int i = 0; i < 3; i++) idle(1);
`ifdef GATE_ARBITER_STATS_EN
        check("gnt_cnt0", {24'd0, gnt_cnt0}, (cnt0 > 255) ? 32'd255 : cnt0);
        check("gnt_cnt1", {24'd0, gnt_cnt1}, (cnt1 > 255) ? 32'd255 : cnt1);
`endif
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result bit width; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock; the block uses a single clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_op  input  1  requester 0 operation: 0 = NAND, 1 = NOR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL be identical to REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result register holds a result.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_y  output  WIDTH  result.

Function
REQ-013 A transfer SHALL occur on reqN when reqN_valid && reqN_ready at a rising clk edge.
REQ-014 reqN_ready SHALL be 1 only when N holds the grant and (!rsp_valid || rsp_ready).
- Ready is combinational from the valids, rsp_valid and rsp_ready.
- The two ready outputs SHALL never both be 1.
REQ-015 Grant rules:
- Only one requester valid: that requester holds the grant.
- Both valid: the requester not recorded in last_grant holds the grant.
REQ-016 last_grant SHALL update to N only on an accepted transfer from N; requests that are not accepted SHALL leave it unchanged.
REQ-017 The result register SHALL be a 2-state machine:
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on rsp_ready with no transfer.
- FULL -> FULL on rsp_ready with a simultaneous transfer (back-to-back, one result per cycle).
REQ-018 On a transfer, the next edge SHALL load:
- rsp_y = op ? ~(a|b) : ~(a&b), bitwise over WIDTH;
- rsp_id = N;
- rsp_valid = 1.
Latency is exactly 1 cycle.
REQ-019 While rsp_valid && !rsp_ready, rsp_y and rsp_id SHALL hold stable and both ready outputs SHALL be 0.
REQ-020 Requesters SHALL hold valid, operands and op stable until accepted; the block does not latch unaccepted requests.

Reset
REQ-021 rst_n low SHALL immediately force:
- rsp_valid = 0, rsp_y = 0, rsp_id = 0;
- last_grant = 1, so that req0 wins the first contest;
- state = EMPTY.
REQ-022 Reset mid-stall SHALL discard the held result; no transfer SHALL occur while rst_n is low.
REQ-023 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro GATE_ARBITER_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (8 bits each).
- Each counter increments on each accepted transfer from its requester and saturates at 255.
- Both counters reset to 0.
REQ-025 Undefined: the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Single request, NAND: WIDTH=8; req0 a=0xF0, b=0x3C, op=0, rsp_ready=1 -> req0_ready=1; next cycle rsp_valid=1, rsp_id=0, rsp_y=0xCF.
REQ-027 Single request, NOR: req1 a=0x0F, b=0x30, op=1 -> next cycle rsp_id=1, rsp_y=0xC0.
REQ-028 Contention after reset: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1, with one rsp_valid per cycle.
REQ-029 Stall: rsp_ready=0 for 3 cycles while FULL -> rsp_y/rsp_id stable and both ready=0; when rsp_ready rises, the pending request is accepted in the same cycle.
REQ-030 Reset mid-stall: rst_n low during a stall -> rsp_valid=0 without a clock edge; after release, the first contested grant goes to req0.
REQ-031 Counters (GATE_ARBITER_STATS_EN defined): 300 accepted req0 transfers -> gnt_cnt0=255 and gnt_cnt1=0.
